// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Collects single-outstanding load/store requests from NUM_LSU LSU lanes,
// round-robin arbitrates them onto one data-memory port and routes each
// response back to the lane that issued it. Only one transaction is in flight
// at a time (IDLE -> ISSUE -> WAIT -> RESPOND -> IDLE).
//
// Optional feature macro: DMEM_ARB_PERF_EN
//   When defined, adds the stall_cycles output. It counts cycles in which some
//   requesting lane is not the currently granted lane, and saturates at all-ones.
//   When undefined, the port and its counter do not exist.
//
// Ports
//   clk             clock
//   reset           asynchronous, active-low reset
//   lsu_valid       per-lane request, held until that lane's response pulse
//   lsu_addr        per-lane address, lane i at [i*ADDR_W +: ADDR_W]
//   lsu_data        per-lane store data
//   lsu_we          per-lane byte write-enables (all zero = load)
//   lsu_resp_ready  one-hot single-cycle response pulse
//   lsu_resp_data   response data, held until the next response
//   mem_req_valid   request to memory
//   mem_req_ready   memory accepts the request
//   mem_req_addr    granted address
//   mem_req_data    granted store data
//   mem_req_we      granted byte enables
//   mem_rsp_valid   memory response strobe
//   mem_rsp_data    memory response data
//   stall_cycles    waiting-cycle counter (DMEM_ARB_PERF_EN only)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int NUM_LSU              = 4,
    parameter int ADDR_W               = 32,
    parameter int DATA_W               = 32,
    parameter int CACHE_LINE_BYTE_SIZE = 4
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_LSU-1:0]                      lsu_valid,
    input  logic [NUM_LSU*ADDR_W-1:0]               lsu_addr,
    input  logic [NUM_LSU*DATA_W-1:0]               lsu_data,
    input  logic [NUM_LSU*CACHE_LINE_BYTE_SIZE-1:0] lsu_we,
    output logic [NUM_LSU-1:0]                      lsu_resp_ready,
    output logic [DATA_W-1:0]                       lsu_resp_data,
    output logic                                    mem_req_valid,
    input  logic                                    mem_req_ready,
    output logic [ADDR_W-1:0]                       mem_req_addr,
    output logic [DATA_W-1:0]                       mem_req_data,
    output logic [CACHE_LINE_BYTE_SIZE-1:0]         mem_req_we,
    input  logic                                    mem_rsp_valid,
    input  logic [DATA_W-1:0]                       mem_rsp_data
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]                             stall_cycles
`endif
);

    localparam int IDX_W = $clog2(NUM_LSU);
    localparam int BE_W  = CACHE_LINE_BYTE_SIZE;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_nx_s;
    logic [IDX_W-1:0]       rr_ptr_r;
    logic [IDX_W-1:0]       rr_ptr_nx_s;
    logic [IDX_W-1:0]       grant_r;
    logic [IDX_W-1:0]       grant_nx_s;
    logic [IDX_W-1:0]       pick_s;
    logic                   any_req_s;

    logic [NUM_LSU-1:0]     resp_ready_nx_s;
    logic [DATA_W-1:0]      resp_data_nx_s;
    logic                   req_valid_nx_s;
    logic [ADDR_W-1:0]      req_addr_nx_s;
    logic [DATA_W-1:0]      req_data_nx_s;
    logic [BE_W-1:0]        req_we_nx_s;

    // First requesting lane at or above ptr, wrapping modulo NUM_LSU.
    // With no request the result is ptr, which is never used.
    function automatic logic [IDX_W-1:0] pick_lane(input logic [NUM_LSU-1:0] req,
                                                   input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] sel;
        logic [IDX_W-1:0] cand;
        logic             found;
        int               idx;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_LSU; k++) begin
            idx  = (int'(ptr) + k) % NUM_LSU;
            cand = IDX_W'(idx);
            if (!found && req[cand]) begin
                sel   = cand;
                found = 1'b1;
            end else begin
                sel   = sel;
                found = found;
            end
        end
        return sel;
    endfunction

    // One-hot vector with only bit g set.
    function automatic logic [NUM_LSU-1:0] lane_onehot(input logic [IDX_W-1:0] g);
        logic [NUM_LSU-1:0] oh;
        oh    = {NUM_LSU{1'b0}};
        oh[g] = 1'b1;
        return oh;
    endfunction

    // Lane after g, wrapping at NUM_LSU (NUM_LSU need not be a power of two).
    function automatic logic [IDX_W-1:0] next_lane(input logic [IDX_W-1:0] g);
        logic [IDX_W-1:0] n;
        if (g == IDX_W'(NUM_LSU - 1)) begin
            n = {IDX_W{1'b0}};
        end else begin
            n = g + IDX_W'(1'b1);
        end
        return n;
    endfunction

    // Round-robin candidate for the current cycle.
    always_comb begin
        pick_s    = pick_lane(lsu_valid, rr_ptr_r);
        any_req_s = |lsu_valid;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_nx_s = ST_ISSUE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_req_ready) begin
                    state_nx_s = ST_WAIT;
                end else begin
                    state_nx_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    state_nx_s = ST_RESPOND;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_RESPOND: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM output logic: next values of the registered outputs and of the
    // grant / round-robin bookkeeping. Everything holds unless a state acts.
    always_comb begin
        resp_ready_nx_s = {NUM_LSU{1'b0}};
        resp_data_nx_s  = lsu_resp_data;
        req_valid_nx_s  = mem_req_valid;
        req_addr_nx_s   = mem_req_addr;
        req_data_nx_s   = mem_req_data;
        req_we_nx_s     = mem_req_we;
        grant_nx_s      = grant_r;
        rr_ptr_nx_s     = rr_ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    // Capture the winner's request; later lane changes cannot
                    // disturb the transaction from here on.
                    grant_nx_s     = pick_s;
                    req_valid_nx_s = 1'b1;
                    req_addr_nx_s  = lsu_addr[pick_s*ADDR_W +: ADDR_W];
                    req_data_nx_s  = lsu_data[pick_s*DATA_W +: DATA_W];
                    req_we_nx_s    = lsu_we[pick_s*BE_W +: BE_W];
                end else begin
                    req_valid_nx_s = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (mem_req_ready) begin
                    req_valid_nx_s = 1'b0;
                end else begin
                    req_valid_nx_s = 1'b1;
                end
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    resp_data_nx_s  = mem_rsp_data;
                    resp_ready_nx_s = lane_onehot(grant_r);
                end else begin
                    resp_ready_nx_s = {NUM_LSU{1'b0}};
                end
            end
            ST_RESPOND: begin
                // Pointer moves past the lane just served, which bounds the
                // wait of any continuously requesting lane.
                rr_ptr_nx_s = next_lane(grant_r);
            end
            default: begin
                req_valid_nx_s = 1'b0;
            end
        endcase
    end

    // Output and bookkeeping registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lsu_resp_ready <= {NUM_LSU{1'b0}};
            lsu_resp_data  <= {DATA_W{1'b0}};
            mem_req_valid  <= 1'b0;
            mem_req_addr   <= {ADDR_W{1'b0}};
            mem_req_data   <= {DATA_W{1'b0}};
            mem_req_we     <= {BE_W{1'b0}};
            grant_r        <= {IDX_W{1'b0}};
            rr_ptr_r       <= {IDX_W{1'b0}};
        end else begin
            lsu_resp_ready <= resp_ready_nx_s;
            lsu_resp_data  <= resp_data_nx_s;
            mem_req_valid  <= req_valid_nx_s;
            mem_req_addr   <= req_addr_nx_s;
            mem_req_data   <= req_data_nx_s;
            mem_req_we     <= req_we_nx_s;
            grant_r        <= grant_nx_s;
            rr_ptr_r       <= rr_ptr_nx_s;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic [NUM_LSU-1:0] granted_oh_s;
    logic               stall_hit_s;

    // Lane owning the port this cycle: the lane being granted while IDLE,
    // otherwise the latched grant.
    always_comb begin
        if (state_r == ST_IDLE) begin
            granted_oh_s = lane_onehot(pick_s);
        end else begin
            granted_oh_s = lane_onehot(grant_r);
        end
        stall_hit_s = |(lsu_valid & ~granted_oh_s);
    end

    // Saturating count of cycles with at least one waiting lane.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= 32'd0;
        end else if (stall_hit_s && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end else begin
            stall_cycles <= stall_cycles;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table of single transactions,
// directed multi-cycle sequences, and a randomized run against a transaction-
// level round-robin model.
module tb_dmem_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    lsu_valid;
    logic [N*AW-1:0] lsu_addr;
    logic [N*DW-1:0] lsu_data;
    logic [N*BW-1:0] lsu_we;
    logic [N-1:0]    lsu_resp_ready;
    logic [DW-1:0]   lsu_resp_data;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [AW-1:0]   mem_req_addr;
    logic [DW-1:0]   mem_req_data;
    logic [BW-1:0]   mem_req_we;
    logic            mem_rsp_valid;
    logic [DW-1:0]   mem_rsp_data;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0]     stall_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.NUM_LSU(N), .ADDR_W(AW), .DATA_W(DW), .CACHE_LINE_BYTE_SIZE(BW)) dut (
        .clk(clk), .reset(reset),
        .lsu_valid(lsu_valid), .lsu_addr(lsu_addr), .lsu_data(lsu_data), .lsu_we(lsu_we),
        .lsu_resp_ready(lsu_resp_ready), .lsu_resp_data(lsu_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_we(mem_req_we),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
`ifdef DMEM_ARB_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    typedef struct {
        logic [N-1:0]  mask;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BW-1:0] we;
        int            rdy_dly;
        int            rsp_dly;
        logic [DW-1:0] rsp;
        int            exp_lane;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [BW-1:0] w);
        lsu_addr[i*AW +: AW] = a;
        lsu_data[i*DW +: DW] = d;
        lsu_we[i*BW +: BW]   = w;
    endtask

    task automatic clear_inputs();
        lsu_valid     = '0;
        lsu_addr      = '0;
        lsu_data      = '0;
        lsu_we        = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_resp_ready"}, 64'(lsu_resp_ready), 64'd0);
        chk({tag, "_resp_data"},  64'(lsu_resp_data),  64'd0);
        chk({tag, "_req_valid"},  64'(mem_req_valid),  64'd0);
        chk({tag, "_req_addr"},   64'(mem_req_addr),   64'd0);
        chk({tag, "_req_data"},   64'(mem_req_data),   64'd0);
        chk({tag, "_req_we"},     64'(mem_req_we),     64'd0);
`ifdef DMEM_ARB_PERF_EN
        chk({tag, "_stall"},      64'(stall_cycles),   64'd0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [N-1:0] onehot(input int lane);
        logic [N-1:0] v;
        v       = '0;
        v[lane] = 1'b1;
        return v;
    endfunction

    // Round-robin rule: first requesting lane counting upward from ptr.
    function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // One complete transaction from an idle arbiter, checked at every step.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        chk("vec_idle_valid", 64'(mem_req_valid), 64'd0);
        for (int i = 0; i < N; i++) begin
            if (i == v.exp_lane) set_lane(i, v.addr, v.data, v.we);
            else                 set_lane(i, ~v.addr, ~v.data, ~v.we);
        end
        lsu_valid = v.mask;
        @(negedge clk);
        chk("vec_req_valid", 64'(mem_req_valid), 64'd1);
        chk("vec_req_addr",  64'(mem_req_addr),  64'(v.addr));
        chk("vec_req_data",  64'(mem_req_data),  64'(v.data));
        chk("vec_req_we",    64'(mem_req_we),    64'(v.we));
        for (int k = 0; k < v.rdy_dly; k++) begin
            mem_req_ready = 1'b0;
            @(negedge clk);
            chk("vec_hold_valid", 64'(mem_req_valid), 64'd1);
            chk("vec_hold_addr",  64'(mem_req_addr),  64'(v.addr));
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("vec_valid_drop", 64'(mem_req_valid), 64'd0);
        for (int k = 0; k < v.rsp_dly; k++) begin
            @(negedge clk);
            chk("vec_no_early_resp", 64'(lsu_resp_ready), 64'd0);
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = v.rsp;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        lsu_valid     = '0;
        chk("vec_resp_lane", 64'(lsu_resp_ready), 64'(onehot(v.exp_lane)));
        chk("vec_resp_data", 64'(lsu_resp_data),  64'(v.rsp));
        @(negedge clk);
        chk("vec_resp_pulse_end", 64'(lsu_resp_ready), 64'd0);
        chk("vec_resp_data_hold", 64'(lsu_resp_data),  64'(v.rsp));
    endtask

    task automatic test_rr_all();
        int order[$];
        do_reset();
        for (int i = 0; i < N; i++) set_lane(i, AW'(32'h100 * i), DW'(i), BW'(0));
        lsu_valid = '1;
        for (int cyc = 0; cyc < 200 && order.size() < 8; cyc++) begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            if (lsu_resp_ready != '0) begin
                for (int b = 0; b < N; b++) if (lsu_resp_ready[b]) order.push_back(b);
                lsu_valid = lsu_valid & ~lsu_resp_ready;
            end else begin
                lsu_valid = '1;
            end
            if (mem_req_ready) begin
                mem_req_ready = 1'b0;
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = $urandom;
            end else if (mem_req_valid) begin
                mem_req_ready = 1'b1;
            end else begin
                mem_req_ready = 1'b0;
            end
        end
        chk("rr_count", 64'(order.size()), 64'd8);
        for (int i = 0; i < order.size(); i++) chk("rr_order", 64'(order[i]), 64'(i % N));
        clear_inputs();
    endtask

    task automatic test_hold();
        do_reset();
        @(negedge clk);
        set_lane(3, 32'h0000_00A0, 32'h5555_AAAA, 4'hF);
        lsu_valid = 4'b1000;
        @(negedge clk);
        chk("hold_first_valid", 64'(mem_req_valid), 64'd1);
        for (int k = 0; k < 5; k++) begin
            mem_req_ready = 1'b0;
            for (int i = 0; i < N; i++) set_lane(i, $urandom, $urandom, BW'($urandom_range(0, 15)));
            lsu_valid = N'($urandom_range(0, 15));
            @(negedge clk);
            chk("hold_valid", 64'(mem_req_valid), 64'd1);
            chk("hold_addr",  64'(mem_req_addr),  64'h0000_00A0);
            chk("hold_data",  64'(mem_req_data),  64'h5555_AAAA);
            chk("hold_we",    64'(mem_req_we),    64'hF);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        lsu_valid     = '0;
        chk("hold_accept", 64'(mem_req_valid), 64'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hCAFE_F00D;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("hold_resp_lane", 64'(lsu_resp_ready), 64'b1000);
        chk("hold_resp_data", 64'(lsu_resp_data),  64'hCAFE_F00D);
        @(negedge clk);
        chk("hold_resp_end", 64'(lsu_resp_ready), 64'd0);
    endtask

    task automatic test_reset_wait();
        do_reset();
        @(negedge clk);
        set_lane(1, 32'h0000_0077, 32'h0000_0011, 4'h3);
        lsu_valid = 4'b0010;
        @(negedge clk);
        chk("rstw_req_valid", 64'(mem_req_valid), 64'd1);
        chk("rstw_req_addr",  64'(mem_req_addr),  64'h77);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("rstw_in_wait", 64'(mem_req_valid), 64'd0);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("rstw_async");
        @(negedge clk);
        reset     = 1'b1;
        lsu_valid = '0;
        @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h1357_9BDF;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("rstw_no_resp",  64'(lsu_resp_ready), 64'd0);
        chk("rstw_no_data",  64'(lsu_resp_data),  64'd0);
        @(negedge clk);
        chk("rstw_no_resp2", 64'(lsu_resp_ready), 64'd0);
        chk("rstw_idle",     64'(mem_req_valid),  64'd0);
    endtask

`ifdef DMEM_ARB_PERF_EN
    task automatic test_perf();
        vec_t v;
        do_reset();
        v = '{mask: 4'b0100, addr: 32'h20, data: 32'h0, we: 4'h0, rdy_dly: 1, rsp_dly: 2,
              rsp: 32'h1, exp_lane: 2};
        run_vec(v);
        chk("perf_single_zero", 64'(stall_cycles), 64'd0);
        do_reset();
        @(negedge clk);
        set_lane(0, 32'h0000_0100, 32'h0, 4'h0);
        set_lane(1, 32'h0000_0200, 32'h0, 4'h0);
        lsu_valid = 4'b0011;
        @(negedge clk);              // grant lane 0, lane 1 waits
        mem_req_ready = 1'b1;
        @(negedge clk);              // accepted
        mem_req_ready = 1'b0;
        @(negedge clk);              // first memory wait cycle
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h55;
        @(negedge clk);              // response pulse to lane 0
        mem_rsp_valid = 1'b0;
        chk("perf_resp_lane0", 64'(lsu_resp_ready), 64'b0001);
        lsu_valid = 4'b0010;
        @(negedge clk);              // respond cycle, lane 1 still waiting
        @(negedge clk);              // lane 1 granted
        chk("perf_lane1_grant", 64'(mem_req_addr), 64'h200);
        chk("perf_two_req",     64'(stall_cycles), 64'd5);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        lsu_valid     = '0;
        @(negedge clk);
        chk("perf_alone_no_inc", 64'(stall_cycles), 64'd5);
    endtask
`endif

    task automatic test_random(input int cycles);
        logic [N-1:0]  pending;
        logic [AW-1:0] r_addr[N];
        logic [DW-1:0] r_data[N];
        logic [BW-1:0] r_we[N];
        logic [N-1:0]  exp_rr, nx_rr;
        logic [DW-1:0] exp_rdata;
        logic          exp_mrv, nx_mrv, model_idle, gap, rdy;
        int            ptr, cur_lane, mem_phase, dly;
        logic [AW-1:0] cur_addr;
        logic [DW-1:0] cur_data;
        logic [BW-1:0] cur_we;
        do_reset();
        pending = '0; exp_rr = '0; exp_rdata = '0; exp_mrv = 1'b0;
        model_idle = 1'b1; gap = 1'b0; ptr = 0; cur_lane = 0; mem_phase = 0; dly = 0;
        cur_addr = '0; cur_data = '0; cur_we = '0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            chk("rnd_resp_ready", 64'(lsu_resp_ready), 64'(exp_rr));
            chk("rnd_resp_data",  64'(lsu_resp_data),  64'(exp_rdata));
            chk("rnd_req_valid",  64'(mem_req_valid),  64'(exp_mrv));
            if (exp_mrv) begin
                chk("rnd_req_addr", 64'(mem_req_addr), 64'(cur_addr));
                chk("rnd_req_data", 64'(mem_req_data), 64'(cur_data));
                chk("rnd_req_we",   64'(mem_req_we),   64'(cur_we));
            end
            // Lane completes on its pulse; the port frees one cycle later.
            if (exp_rr != '0) begin
                pending[cur_lane]   = 1'b0;
                lsu_valid[cur_lane] = 1'b0;
                gap = 1'b1;
            end else if (gap) begin
                gap        = 1'b0;
                model_idle = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && $urandom_range(0, 3) == 0) begin
                    pending[i] = 1'b1;
                    r_addr[i]  = $urandom;
                    r_data[i]  = $urandom;
                    r_we[i]    = BW'($urandom_range(0, 15));
                    set_lane(i, r_addr[i], r_data[i], r_we[i]);
                    lsu_valid[i] = 1'b1;
                end
            end
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            nx_rr         = '0;
            nx_mrv        = 1'b0;
            if (mem_phase == 0 && exp_mrv) begin
                rdy           = ($urandom_range(0, 2) == 0);
                mem_req_ready = rdy;
                nx_mrv        = !rdy;
                if (rdy) begin
                    mem_phase = 1;
                    dly       = $urandom_range(0, 3);
                end
            end else if (mem_phase == 1) begin
                if (dly == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = $urandom;
                    exp_rdata     = mem_rsp_data;
                    nx_rr         = onehot(cur_lane);
                    mem_phase     = 0;
                end else begin
                    dly--;
                end
            end else begin
                if ($urandom_range(0, 7) == 0) begin
                    mem_rsp_valid = 1'b1;      // stray strobe, must be ignored
                    mem_rsp_data  = $urandom;
                end
                if (model_idle && lsu_valid != '0) begin
                    cur_lane   = rr_pick(lsu_valid, ptr);
                    ptr        = (cur_lane + 1) % N;
                    cur_addr   = r_addr[cur_lane];
                    cur_data   = r_data[cur_lane];
                    cur_we     = r_we[cur_lane];
                    model_idle = 1'b0;
                    nx_mrv     = 1'b1;
                end
            end
            exp_rr  = nx_rr;
            exp_mrv = nx_mrv;
        end
        clear_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before the test sequence ended");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        tbl[0] = '{mask: 4'b0100, addr: 32'h0000_0040, data: 32'h0, we: 4'b0000,
                   rdy_dly: 0, rsp_dly: 1, rsp: 32'hDEAD_BEEF, exp_lane: 2};
        tbl[1] = '{mask: 4'b0001, addr: 32'h0000_0010, data: 32'h1234_5678, we: 4'b0011,
                   rdy_dly: 2, rsp_dly: 3, rsp: 32'h0BAD_F00D, exp_lane: 0};
        tbl[2] = '{mask: 4'b1111, addr: 32'h0000_1000, data: 32'hA5A5_0001, we: 4'b1111,
                   rdy_dly: 0, rsp_dly: 0, rsp: 32'h0000_0001, exp_lane: 1};
        tbl[3] = '{mask: 4'b1001, addr: 32'h0000_2000, data: 32'hA5A5_0002, we: 4'b0100,
                   rdy_dly: 1, rsp_dly: 0, rsp: 32'h0000_0002, exp_lane: 3};
        tbl[4] = '{mask: 4'b1010, addr: 32'h0000_3000, data: 32'hA5A5_0003, we: 4'b0000,
                   rdy_dly: 0, rsp_dly: 2, rsp: 32'h0000_0003, exp_lane: 1};
        tbl[5] = '{mask: 4'b0011, addr: 32'h0000_4000, data: 32'hA5A5_0004, we: 4'b1000,
                   rdy_dly: 3, rsp_dly: 1, rsp: 32'hFFFF_FFFF, exp_lane: 0};
        tbl[6] = '{mask: 4'b1000, addr: 32'hFFFF_FFFC, data: 32'hA5A5_0005, we: 4'b0001,
                   rdy_dly: 0, rsp_dly: 0, rsp: 32'h8000_0000, exp_lane: 3};
        do_reset();
        for (int i = 0; i < 7; i++) run_vec(tbl[i]);
        test_rr_all();
        test_hold();
        test_reset_wait();
`ifdef DMEM_ARB_PERF_EN
        test_perf();
`endif
        test_random(1500);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
